// File: rtl/isa_track_pkg.sv
// Shared types and helpers for the shadow pipeline tracker.
// Optional build macro: ISA_TRACK_RVC_EN (compressed-instruction aware alignment).
package isa_track_pkg;

  // Widest PC the stage record carries; the top zero-extends narrower PCs into it.
  localparam int PC_W = 64;

  localparam logic [31:0] PC_INIT_DEF  = 32'h0000_0200;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     insn;
    logic            bubble;
  } stage_t;

  // Fetch PC alignment: halfword when compressed instructions exist, word otherwise.
  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
`ifdef ISA_TRACK_RVC_EN
    return pc & ~(PC_W'(1));
`else
    return pc & ~(PC_W'(3));
`endif
  endfunction

  // Compressed encodings only occupy the low halfword; clear the rest so the
  // stored word does not depend on whatever followed it in the fetch buffer.
  function automatic logic [31:0] insn_fix(input logic [31:0] insn);
`ifdef ISA_TRACK_RVC_EN
    if (insn[1:0] != 2'b11) begin
      return {16'h0000, insn[15:0]};
    end
`endif
    return insn;
  endfunction

endpackage

// File: rtl/isa_track_stage.sv
// One tracked pipeline stage: flush beats stall, and an upstream stall
// turns this stage into a bubble instead of letting stale data advance.
module isa_track_stage
  import isa_track_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RST   = PC_W'(PC_INIT_DEF),
  parameter logic [31:0]     INSN_RST = NOP_INSN_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t src,
  input  logic   flush,
  input  logic   stall,
  input  logic   up_stall,
  output stage_t q
);

  // Stage register: flush > stall(hold) > upstream stall(bubble) > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.pc     <= PC_RST;
      q.insn   <= INSN_RST;
      q.bubble <= 1'b1;
    end else if (flush) begin
      q.bubble <= 1'b1;
    end else if (!stall) begin
      if (up_stall) begin
        q.bubble <= 1'b1;
      end else begin
        q <= src;
      end
    end
  end

endmodule

// File: rtl/isa_pipe_tracker.sv
// Shadow pipeline / register-file tracker bound beside the RV12 core.
// Mirrors IF through STAGES stages under external stall/flush control,
// reports retirements and keeps a shadow register file with a sticky
// mismatch flag. Optional build macro: ISA_TRACK_RVC_EN.
// XLEN is limited to 64 by the stage record width.
module isa_pipe_tracker
  import isa_track_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                STAGES   = 5,
  parameter logic [XLEN-1:0]   PC_INIT  = XLEN'(PC_INIT_DEF),
  parameter logic [31:0]       NOP_INSN = NOP_INSN_DEF,
  parameter int                RF_REGS  = 32,
  parameter int                CNT_W    = 64,
  localparam int               RIDX     = (RF_REGS > 1) ? $clog2(RF_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [XLEN-1:0]          if_pc_i,
  input  logic [31:0]              if_insn_i,
  input  logic                     if_bubble_i,
  input  logic [STAGES-1:0]        stall_i,
  input  logic [STAGES-1:0]        flush_i,
  output logic [STAGES*XLEN-1:0]   st_pc_o,
  output logic [STAGES*32-1:0]     st_insn_o,
  output logic [STAGES-1:0]        st_bubble_o,
  output logic                     retire_valid_o,
  output logic [XLEN-1:0]          retire_pc_o,
  output logic [31:0]              retire_insn_o,
  output logic [CNT_W-1:0]         retire_cnt_o,
  input  logic                     wb_we_i,
  input  logic [RIDX-1:0]          wb_dst_i,
  input  logic [XLEN-1:0]          wb_value_i,
  input  logic [RIDX-1:0]          cmp_idx_i,
  input  logic [XLEN-1:0]          cmp_val_i,
  output logic                     rf_mismatch_o
);

  localparam logic [PC_W-1:0] PC_INIT_EXT = PC_W'(PC_INIT);

  stage_t src0;
  stage_t q [STAGES];

  // IF boundary: align the fetch PC and normalise the instruction word
  always_comb begin
    src0        = '0;
    src0.pc     = pc_align(PC_W'(if_pc_i));
    src0.insn   = insn_fix(if_insn_i);
    src0.bubble = if_bubble_i;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t src;
    logic   up_stall;

    if (k == 0) begin : g_head
      assign src      = src0;
      assign up_stall = 1'b0;
    end else begin : g_body
      assign src      = q[k-1];
      assign up_stall = stall_i[k-1];
    end

    isa_track_stage #(
      .PC_RST   (PC_INIT_EXT),
      .INSN_RST (NOP_INSN)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (src),
      .flush    (flush_i[k]),
      .stall    (stall_i[k]),
      .up_stall (up_stall),
      .q        (q[k])
    );

    assign st_pc_o[k*XLEN +: XLEN] = q[k].pc[XLEN-1:0];
    assign st_insn_o[k*32 +: 32]   = q[k].insn;
    assign st_bubble_o[k]          = q[k].bubble;

    // Upper PC bits are always zero here; they exist only to fit the shared record.
    if (XLEN < PC_W) begin : g_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^q[k].pc[PC_W-1:XLEN];
    end
  end

  // Retirement: the last stage leaves the pipe only when it is neither held nor killed.
  assign retire_valid_o = ~q[STAGES-1].bubble & ~stall_i[STAGES-1] & ~flush_i[STAGES-1];
  assign retire_pc_o    = q[STAGES-1].pc[XLEN-1:0];
  assign retire_insn_o  = q[STAGES-1].insn;

  logic [CNT_W-1:0] retire_cnt_q;

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (retire_valid_o) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt_o = retire_cnt_q;

  logic [XLEN-1:0] rf [RF_REGS];
  logic [XLEN-1:0] rf_rd;
  logic            rf_wr;
  logic            mismatch_q;

  // x0 and out-of-range indices are never written, so x0 keeps its reset zero.
  assign rf_wr = wb_we_i && (wb_dst_i != '0) && (int'(wb_dst_i) < RF_REGS);

  // Shadow register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (rf_wr) begin
      rf[wb_dst_i] <= wb_value_i;
    end
  end

  // Compare read port sees the pre-edge contents, matching the core's own file.
  always_comb begin
    rf_rd = '0;
    if (int'(cmp_idx_i) < RF_REGS) begin
      rf_rd = rf[cmp_idx_i];
    end
  end

  // Sticky registered mismatch flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (rf_rd != cmp_val_i) begin
      mismatch_q <= 1'b1;
    end
  end

  assign rf_mismatch_o = mismatch_q;

endmodule

// File: tb/tb_isa_pipe_tracker.sv
// Directed bench for isa_pipe_tracker with a retirement scoreboard.
module tb_isa_pipe_tracker;

  localparam int XLEN   = 32;
  localparam int STAGES = 5;
  localparam int RIDX   = 5;
  localparam int CNT_W  = 64;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [XLEN-1:0]         if_pc_i;
  logic [31:0]             if_insn_i;
  logic                    if_bubble_i;
  logic [STAGES-1:0]       stall_i;
  logic [STAGES-1:0]       flush_i;
  logic [STAGES*XLEN-1:0]  st_pc_o;
  logic [STAGES*32-1:0]    st_insn_o;
  logic [STAGES-1:0]       st_bubble_o;
  logic                    retire_valid_o;
  logic [XLEN-1:0]         retire_pc_o;
  logic [31:0]             retire_insn_o;
  logic [CNT_W-1:0]        retire_cnt_o;
  logic                    wb_we_i;
  logic [RIDX-1:0]         wb_dst_i;
  logic [XLEN-1:0]         wb_value_i;
  logic [RIDX-1:0]         cmp_idx_i;
  logic [XLEN-1:0]         cmp_val_i;
  logic                    rf_mismatch_o;

  isa_pipe_tracker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc_i        (if_pc_i),
    .if_insn_i      (if_insn_i),
    .if_bubble_i    (if_bubble_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .st_pc_o        (st_pc_o),
    .st_insn_o      (st_insn_o),
    .st_bubble_o    (st_bubble_o),
    .retire_valid_o (retire_valid_o),
    .retire_pc_o    (retire_pc_o),
    .retire_insn_o  (retire_insn_o),
    .retire_cnt_o   (retire_cnt_o),
    .wb_we_i        (wb_we_i),
    .wb_dst_i       (wb_dst_i),
    .wb_value_i     (wb_value_i),
    .cmp_idx_i      (cmp_idx_i),
    .cmp_val_i      (cmp_val_i),
    .rf_mismatch_o  (rf_mismatch_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t        sb[$];
  int          tests   = 0;
  int          fails   = 0;
  int          pushed  = 0;
  int          dropped = 0;
  logic [31:0] next_pc;
  logic [31:0] flush_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0093};
  endfunction

  function automatic logic [31:0] spc(input int k);
    return st_pc_o[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] sinsn(input int k);
    return st_insn_o[k*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input bit valid);
    if (valid) begin
      if_bubble_i = 1'b0;
      if_pc_i     = next_pc;
      if_insn_i   = insn_of(next_pc);
      sb.push_back('{pc: next_pc, insn: insn_of(next_pc)});
      pushed++;
      next_pc     = next_pc + 32'd4;
    end else begin
      if_bubble_i = 1'b1;
    end
  endtask

  task automatic drop_pc(input logic [31:0] pc);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].pc == pc) begin
        sb.delete(i);
        dropped++;
        break;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < STAGES; k++) begin
      chk({tag, "_bubble"}, st_bubble_o[k], 1'b1);
      chk({tag, "_pc"}, spc(k), 32'h200);
      chk({tag, "_insn"}, sinsn(k), 32'h13);
    end
    chk({tag, "_rvalid"}, retire_valid_o, 1'b0);
    chk({tag, "_cnt"}, retire_cnt_o, 64'd0);
    chk({tag, "_mm"}, rf_mismatch_o, 1'b0);
  endtask

  // Retirement monitor: every retiring instruction must be the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && retire_valid_o === 1'b1) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL retire_unexpected: observed pc %0h expected none", retire_pc_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_pc", retire_pc_o, e.pc);
        chk("retire_insn", retire_insn_o, e.insn);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    if_pc_i     = '0;
    if_insn_i   = '0;
    if_bubble_i = 1'b1;
    stall_i     = '0;
    flush_i     = '0;
    wb_we_i     = 1'b0;
    wb_dst_i    = '0;
    wb_value_i  = '0;
    cmp_idx_i   = '0;
    cmp_val_i   = '0;
    next_pc     = 32'h200;
    flush_pc    = '0;

    repeat (3) tick();
    chk_reset("por");

    // Stream from IF; edge n carries pc driven just before it.
    drive_if(1'b1);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      case (e)
        1: begin
          chk("s0_pc_e1", spc(0), 32'h200);
          chk("s0_bub_e1", st_bubble_o[0], 1'b0);
          chk("s1_bub_e1", st_bubble_o[1], 1'b1);
        end
        4: chk("cnt_e4", retire_cnt_o, 64'd0);
        5: begin
          chk("s4_pc_e5", spc(4), 32'h200);
          chk("s4_bub_e5", st_bubble_o[4], 1'b0);
          chk("rvalid_e5", retire_valid_o, 1'b1);
          chk("cnt_e5", retire_cnt_o, 64'd0);
        end
        6: chk("cnt_e6", retire_cnt_o, 64'd1);
        9, 10: begin
          chk("stall_s2_pc", spc(2), 32'h214);
          chk("stall_s2_insn", sinsn(2), insn_of(32'h214));
          chk("stall_s2_bub", st_bubble_o[2], 1'b0);
          chk("stall_s3_bub", st_bubble_o[3], 1'b1);
          if (e == 10) chk("cnt_e10", retire_cnt_o, 64'd5);
        end
        12: chk("cnt_e12", retire_cnt_o, 64'd5);
        13: chk("cnt_e13", retire_cnt_o, 64'd6);
        14: chk("cnt_e14", retire_cnt_o, 64'd7);
        15: begin
          chk("pre_flush_s1_bub", st_bubble_o[1], 1'b0);
          chk("pre_flush_s1_pc", spc(1), flush_pc);
        end
        16: begin
          chk("flush_s1_bub", st_bubble_o[1], 1'b1);
          chk("flush_s1_pc", spc(1), flush_pc);
          chk("flush_s2_bub", st_bubble_o[2], 1'b1);
          chk("flush_s0_pc", spc(0), 32'h230);
        end
        default: ;
      endcase

      // Inputs for edge e+1
      stall_i = '0;
      flush_i = '0;
      if (e + 1 == 9 || e + 1 == 10) stall_i = 5'b00100;
      if (e + 1 == 14) flush_pc = next_pc;
      if (e + 1 == 16) begin
        stall_i = 5'b00010;
        flush_i = 5'b00010;
        drop_pc(flush_pc);
      end
      drive_if((e + 1 <= 20) && (e + 1 != 7) && (e + 1 != 8) && (e + 1 != 15));
    end

    stall_i = '0;
    flush_i = '0;
    drive_if(1'b0);
    repeat (10) tick();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_cnt", retire_cnt_o, 64'(pushed - dropped));

    // Shadow register file: matching value, then a sticky mismatch.
    wb_we_i    = 1'b1;
    wb_dst_i   = 5'd5;
    wb_value_i = 32'hDEAD_BEEF;
    tick();
    wb_we_i   = 1'b0;
    cmp_idx_i = 5'd5;
    cmp_val_i = 32'hDEAD_BEEF;
    tick();
    chk("rf_match_1", rf_mismatch_o, 1'b0);
    tick();
    chk("rf_match_2", rf_mismatch_o, 1'b0);
    cmp_val_i = 32'h0;
    chk("rf_mm_latency", rf_mismatch_o, 1'b0);
    tick();
    chk("rf_mm_set", rf_mismatch_o, 1'b1);
    cmp_val_i = 32'hDEAD_BEEF;
    tick();
    chk("rf_mm_sticky_1", rf_mismatch_o, 1'b1);
    tick();
    chk("rf_mm_sticky_2", rf_mismatch_o, 1'b1);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 7; i++) begin
      drive_if(1'b1);
      tick();
    end
    chk("pre_rst_s4_bub", st_bubble_o[4], 1'b0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset("midrst");
    drive_if(1'b0);
    sb.delete();
    tick();
    rst_n     = 1'b1;
    cmp_idx_i = 5'd5;
    cmp_val_i = 32'h0;
    tick();
    chk("rf_cleared_by_rst", rf_mismatch_o, 1'b0);

    // x0 ignores writes.
    wb_we_i    = 1'b1;
    wb_dst_i   = 5'd0;
    wb_value_i = 32'h1234;
    cmp_idx_i  = 5'd0;
    cmp_val_i  = 32'h0;
    tick();
    wb_we_i = 1'b0;
    tick();
    chk("rf_x0_1", rf_mismatch_o, 1'b0);
    tick();
    chk("rf_x0_2", rf_mismatch_o, 1'b0);

    // Same-cycle write and compare sees the old value.
    wb_we_i    = 1'b1;
    wb_dst_i   = 5'd7;
    wb_value_i = 32'h55;
    cmp_idx_i  = 5'd7;
    cmp_val_i  = 32'h0;
    tick();
    chk("rf_same_cycle_old", rf_mismatch_o, 1'b0);
    wb_we_i   = 1'b0;
    cmp_val_i = 32'h55;
    tick();
    chk("rf_new_visible", rf_mismatch_o, 1'b0);
    cmp_val_i = 32'h0;
    tick();
    chk("rf_x7_written", rf_mismatch_o, 1'b1);

    // Stage 0 alignment and instruction normalisation.
    if_bubble_i = 1'b1;
    if_pc_i     = 32'h206;
    if_insn_i   = 32'hABCD_4501;
    tick();
    chk("align_bub", st_bubble_o[0], 1'b1);
`ifdef ISA_TRACK_RVC_EN
    chk("align_pc", spc(0), 32'h206);
    chk("align_insn", sinsn(0), 32'h0000_4501);
`else
    chk("align_pc", spc(0), 32'h204);
    chk("align_insn", sinsn(0), 32'hABCD_4501);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/isa_pipe_tracker.md
Name: isa_pipe_tracker

Overview:
- Parametrised shadow pipeline and register-file tracker for the RV12 core's formal environment.
- Mirrors the instruction stream through STAGES pipeline stages after IF, driven by per-stage stall/flush vectors instead of hard-wired stage logic.
- Exposes per-stage pc/insn/bubble, a retirement stream and counter, and a shadow register file with a registered mismatch flag.
- Bound beside the core; assertions compare its outputs against core stage outputs.

Parameters:
- XLEN, 32, data/PC width
- STAGES, 5, number of tracked stages after IF (PD, ID, EX, MEM, WB); legal range 2..8
- PC_INIT, 32'h200, reset PC of every stage
- NOP_INSN, 32'h13, reset instruction of every stage
- RF_REGS, 32, shadow register count; index width RIDX = $clog2(RF_REGS)
- CNT_W, 64, retirement counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- if_pc_i  in  XLEN  IF-stage PC
- if_insn_i  in  32  IF-stage instruction
- if_bubble_i  in  1  IF slot is a bubble
- stall_i  in  STAGES  bit k=1: stage k holds
- flush_i  in  STAGES  bit k=1: stage k becomes a bubble
- st_pc_o  out  STAGES*XLEN  per-stage PC, stage k at [k*XLEN +: XLEN]
- st_insn_o  out  STAGES*32  per-stage instruction
- st_bubble_o  out  STAGES  per-stage bubble
- retire_valid_o  out  1  last stage retires this cycle
- retire_pc_o  out  XLEN  retiring PC
- retire_insn_o  out  32  retiring instruction
- retire_cnt_o  out  CNT_W  retired-instruction count
- wb_we_i  in  1  core writeback enable
- wb_dst_i  in  RIDX  writeback destination
- wb_value_i  in  XLEN  writeback data
- cmp_idx_i  in  RIDX  register index to compare
- cmp_val_i  in  XLEN  core register-file value at cmp_idx_i
- rf_mismatch_o  out  1  registered compare failure

Behaviour:
- Reset and clocking: clk is the only clock. rst_n is asynchronous, active-low.
- Reset values: every stage gets pc=PC_INIT, insn=NOP_INSN, bubble=1. retire_cnt_o=0, all shadow registers 0, rf_mismatch_o=0. retire_valid_o=0 follows from bubble=1.
- Source of each stage: stage 0 loads from IF with pc masked to word alignment (pc & ~3). Stage k>0 loads from stage k-1.
- Per-stage update, priority order:
  - flush_i[k]: bubble←1; pc/insn hold.
  - else stall_i[k]: hold everything.
  - else if k>0 and stall_i[k-1]: bubble←1, so a stall upstream inserts a bubble downstream.
  - else load from source, including its bubble.
- Flush beats stall in the same cycle. Stage 0 with stall_i[0]=0 always loads IF.
- Latency: an IF instruction reaches stage k after k+1 unstalled cycles.
- Retirement (combinational): retire_valid_o = ~bubble[STAGES-1] & ~stall_i[STAGES-1] & ~flush_i[STAGES-1]. retire_pc_o and retire_insn_o come from the last stage.
- retire_cnt_o increments by 1 on each retire_valid_o cycle and wraps modulo 2^CNT_W.
- Shadow register file:
  - Write when wb_we_i && wb_dst_i!=0; the value is visible the next cycle.
  - Writes to x0 are ignored; x0 always reads 0.
  - Indices ≥ RF_REGS are ignored.
- Mismatch flag: rf_mismatch_o ← (shadow[cmp_idx_i] != cmp_val_i), computed from the pre-edge shadow value and registered (one-cycle latency).
  - It is sticky: once set it stays set until reset.
  - A write and a compare to the same index in one cycle compare the old value. The core's register file is updated on the same edge, so the two stay aligned.
- Reset mid-operation discards all in-flight stages immediately (asynchronous).

Optional Feature:
- Macro ISA_TRACK_RVC_EN.
- Defined:
  - stage 0 PC mask is ~1 (halfword aligned);
  - an instruction with insn[1:0]!=2'b11 is stored with bits [31:16] zeroed.
- Undefined: PC mask ~3; instructions are stored unmodified.

Decomposition:
- Package isa_track_pkg holds:
  - stage_t struct {pc, insn, bubble};
  - PC_INIT_DEF and NOP_INSN_DEF constants;
  - a function pc_align().
- Sub-module isa_track_stage: one stage register with the flush/stall/upstream-stall priority logic, instantiated STAGES times in a generate loop.

Test Plan:
- Release reset with IF streaming pc=0x200,0x204,… all non-bubble, no stalls → st_pc_o stage 4 = 0x200 on cycle 5; retire_cnt_o=1 on cycle 6.
- stall_i=5'b00100 for 2 cycles → stage 2 holds its insn; stage 3 shows bubble for 2 cycles; retire_cnt_o advance is delayed by 2.
- flush_i[1] and stall_i[1] both high with stage 1 valid → stage 1 bubble=1 next cycle; the flushed pc never retires.
- wb_we_i=1, wb_dst_i=5, wb_value_i=0xDEADBEEF; next cycle cmp_idx_i=5, cmp_val_i=0xDEADBEEF → rf_mismatch_o stays 0. Then cmp_val_i=0 → rf_mismatch_o=1 one cycle later and stays set.
- wb_dst_i=0 with wb_value_i=0x1234, then compare idx 0 with value 0 → no mismatch.
- Assert rst_n mid-stream → all st_bubble_o=1, st_pc_o=0x200, retire_cnt_o=0 immediately. With ISA_TRACK_RVC_EN, if_pc_i=0x206 and if_insn_i=0xABCD4501 → stage 0 pc=0x206, insn=0x00004501.
